// File: rtl/data_memory_ctrl.sv
// Byte-addressed, big-endian data memory with a valid/ready request port and a
// registered response pulse. Handles byte/half/word loads and stores, and flags
// misaligned, out-of-range and illegal-size accesses.
module data_memory_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
  localparam int unsigned CNT_W = 3;
  localparam int unsigned EXT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hold_rdata;
  logic             hold_err;

  logic [7:0]       mem [DEPTH_BYTES];

  logic             accept;
  logic [2:0]       size_bytes;
  logic [EXT_W-1:0] end_addr;
  logic             misaligned;
  logic             out_of_range;
  logic             illegal_size;
  logic             err_c;
  logic [IDX_W-1:0] idx;
  logic [7:0]       b0, b1, b2, b3;
  logic [31:0]      load_c;
  logic [31:0]      resp_c;

  // Only IDLE drives req_ready high, so this is the single acceptance point.
  assign accept = req_valid && req_ready;

  // Access width in bytes; illegal size is flagged separately.
  always_comb begin
    size_bytes = 3'd1;
    case (req_size)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      2'b10:   size_bytes = 3'd4;
      default: size_bytes = 3'd1;
    endcase
  end

  // End address computed one bit wider so accesses near the top cannot wrap.
  assign end_addr     = {1'b0, req_addr} + EXT_W'(size_bytes);
  assign out_of_range = end_addr > EXT_W'(DEPTH_BYTES);
  assign misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign illegal_size = (req_size == 2'b11);
  assign err_c        = misaligned || out_of_range || illegal_size;

  // Big-endian byte lanes: b0 is the lowest address and most significant byte.
  assign idx = req_addr[IDX_W-1:0];
  assign b0  = mem[idx];
  assign b1  = mem[idx + IDX_W'(1)];
  assign b2  = mem[idx + IDX_W'(2)];
  assign b3  = mem[idx + IDX_W'(3)];

  // Load data with sign or zero extension.
  always_comb begin
    load_c = '0;
    case (req_size)
      2'b00:   load_c = req_unsigned ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   load_c = req_unsigned ? {16'h0, b0, b1} : {{16{b0[7]}}, b0, b1};
      2'b10:   load_c = {b0, b1, b2, b3};
      default: load_c = '0;
    endcase
  end

  assign resp_c = (err_c || req_we) ? 32'h0 : load_c;

  // Store commit at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err_c) begin
      case (req_size)
        2'b00: mem[idx] <= req_wdata[7:0];
        2'b01: begin
          mem[idx]              <= req_wdata[15:8];
          mem[idx + IDX_W'(1)]  <= req_wdata[7:0];
        end
        2'b10: begin
          mem[idx]              <= req_wdata[31:24];
          mem[idx + IDX_W'(1)]  <= req_wdata[23:16];
          mem[idx + IDX_W'(2)]  <= req_wdata[15:8];
          mem[idx + IDX_W'(3)]  <= req_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // Request/response sequencing with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      hold_rdata <= '0;
      hold_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            if (LATENCY <= 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= resp_c;
              resp_err   <= err_c;
            end else begin
              state      <= WAIT;
              cnt        <= CNT_W'(LATENCY - 1);
              hold_rdata <= resp_c;
              hold_err   <= err_c;
            end
          end
        end
        WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= hold_rdata;
            resp_err   <= hold_err;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
